// File: rtl/cube_if.sv
// Handshake and data bundle for the iterative cube unit: operand/start in, busy/result out.
interface cube_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   x_bi;
    logic               start_i;
    logic               busy_o;
    logic [3*WIDTH-1:0] y_bo;

    modport master (output x_bi, output start_i, input busy_o, input y_bo);
    modport slave  (input x_bi, input start_i, output busy_o, output y_bo);
endinterface

// File: rtl/cube.sv
// Iterative unsigned cube y = x^3 using a radix-2 shift-add datapath, one multiplier bit per clock.
// Optional macro CUBE_EARLY_EXIT_EN ends each multiply phase once the remaining multiplier bits are zero.
module cube #(
    parameter int WIDTH = 8
) (
    input  logic  clk_i,
    input  logic  rst_i,
    cube_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        MUL2 = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [3*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [3*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3*WIDTH-1:0] y_q, y_d;

    logic [3*WIDTH-1:0] sum_s;
    logic [WIDTH-1:0]   mplier_shr_s;
    logic [2*WIDTH-1:0] sq_s;
    logic               last_s;

    // Datapath step terms shared by both multiply phases
    always_comb begin
        sum_s        = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_shr_s = mplier_q >> 1;
        sq_s         = sum_s[2*WIDTH-1:0];
`ifdef CUBE_EARLY_EXIT_EN
        last_s       = (cnt_q == CW'(WIDTH - 1)) || (mplier_shr_s == {WIDTH{1'b0}});
`else
        last_s       = (cnt_q == CW'(WIDTH - 1));
`endif
    end

    // Next-state and register updates for the control FSM
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    x_d      = bus.x_bi;
                    mcand_d  = {{(2*WIDTH){1'b0}}, bus.x_bi};
                    mplier_d = bus.x_bi;
                    acc_d    = {(3*WIDTH){1'b0}};
                    cnt_d    = {CW{1'b0}};
                    state_d  = MUL1;
                end else begin
                    state_d  = IDLE;
                end
            end
            MUL1: begin
                if (last_s) begin
                    // The square (never wider than 2*WIDTH) becomes the multiplicand of phase two
                    mcand_d  = {{WIDTH{1'b0}}, sq_s};
                    mplier_d = x_q;
                    acc_d    = {(3*WIDTH){1'b0}};
                    cnt_d    = {CW{1'b0}};
                    state_d  = MUL2;
                end else begin
                    acc_d    = sum_s;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_shr_s;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            MUL2: begin
                if (last_s) begin
                    acc_d    = sum_s;
                    state_d  = DONE;
                end else begin
                    acc_d    = sum_s;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_shr_s;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            DONE: begin
                y_d     = acc_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            x_q      <= {WIDTH{1'b0}};
            mcand_q  <= {(3*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {(3*WIDTH){1'b0}};
            cnt_q    <= {CW{1'b0}};
            y_q      <= {(3*WIDTH){1'b0}};
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
        end
    end

    assign bus.busy_o = (state_q != IDLE);
    assign bus.y_bo   = y_q;
endmodule

// File: tb/tb_cube.sv
// Self-checking bench for cube: directed cases, held-start, mid-op reset, sweep and random operands.
module tb_cube;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cube_if #(.WIDTH(W)) bus ();

    cube #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_latency(input int x);
`ifdef CUBE_EARLY_EXIT_EN
        int bl;
        bl = $clog2(x + 1);
        if (bl < 1) bl = 1;
        return 2 * bl + 1;
`else
        return 2 * W + 1;
`endif
    endfunction

    // Issue one operation and check busy length, result and output stability
    task automatic run_op(input int x, input string tag);
        int     cyc;
        longint y_prev;
        longint exp_y;
        exp_y = longint'(x) * longint'(x) * longint'(x);
        @(negedge clk);
        bus.x_bi    = W'(x);
        bus.start_i = 1'b1;
        y_prev      = longint'(bus.y_bo);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.x_bi    = W'($urandom);
        cyc = 0;
        while (bus.busy_o === 1'b1 && cyc < 100) begin
            if (longint'(bus.y_bo) != y_prev) begin
                check({tag, "_stable"}, longint'(bus.y_bo), y_prev);
            end
            cyc++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, cyc, exp_latency(x));
        check({tag, "_y"}, longint'(bus.y_bo), exp_y);
    endtask

    // Wait for busy to drop with a cycle bound
    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        while (bus.busy_o === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 100) check({tag, "_timeout"}, cyc, 0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.x_bi    = '0;
        bus.start_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", longint'(bus.busy_o), 0);
        check("reset_y", longint'(bus.y_bo), 0);
        rst = 1'b0;

        run_op(0, "x0");
        run_op(3, "x3");
        run_op(17, "x17");
        run_op(255, "x255");
        run_op(1, "x1");

        // Start held high while operand changes mid-operation
        @(negedge clk);
        bus.x_bi    = 8'd5;
        bus.start_i = 1'b1;
        repeat (3) @(negedge clk);
        bus.x_bi = 8'd200;
        wait_idle("hold1");
        check("hold_first_y", longint'(bus.y_bo), 125);
        @(negedge clk);
        check("hold_second_accepted", longint'(bus.busy_o), 1);
        wait_idle("hold2");
        bus.start_i = 1'b0;
        check("hold_second_y", longint'(bus.y_bo), 8000000);
        @(negedge clk);
        check("hold_idle_after", longint'(bus.busy_o), 0);

        // Reset abandons an operation in flight
        @(negedge clk);
        bus.x_bi    = 8'd100;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_busy_before", longint'(bus.busy_o), 1);
        rst         = 1'b1;
        bus.start_i = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        bus.start_i = 1'b0;
        check("midrst_busy", longint'(bus.busy_o), 0);
        check("midrst_y", longint'(bus.y_bo), 0);
        run_op(2, "after_rst_x2");

        for (int i = 0; i < 256; i++) begin
            run_op(i, "sweep");
        end

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(int'($urandom_range(0, 255)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
